biquad8_coeff_loader: RTL
=========================

BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 SHALL have parameter NCOEFF, default 2, meaning the number of 18-bit coefficient words streamed per load (1..2^ADDR_BITS).
REQ-002 SHALL have parameter ADDR_BITS, default 3, meaning the host buffer address width.
REQ-003 SHALL have parameter WR_GAP, default 0, meaning the idle cycles inserted between consecutive coefficient writes (0..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the reset; asynchronous and active-high.
REQ-006 SHALL have port host_addr_i, input, ADDR_BITS bits: the buffer write address.
REQ-007 SHALL have port host_dat_i, input, 18 bits: the buffer write data.
REQ-008 SHALL have port host_wr_i, input, 1 bit: the buffer write strobe.
REQ-009 SHALL have port start_i, input, 1 bit: the load-sequence request.
REQ-010 SHALL have port busy_o, output, 1 bit: high while a sequence is in progress.
REQ-011 SHALL have port done_o, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1 bit: a sticky flag set by a host write or start while busy.
REQ-013 SHALL have port coeff_dat_o, output, 18 bits: drives the filter's coeff_dat_i.
REQ-014 SHALL have port coeff_wr_o, output, 1 bit: drives the filter's coeff_wr_i.
REQ-015 SHALL have port coeff_update_o, output, 1 bit: drives the filter's coeff_update_i.

Function
REQ-016 SHALL hold an NCOEFF x 18 register buffer; in IDLE, host_wr_i with host_addr_i < NCOEFF SHALL write host_dat_i to that entry; addresses >= NCOEFF SHALL be ignored and SHALL NOT set err_o.
REQ-017 SHALL implement the FSM IDLE -> WRITE -> GAP -> UPDATE -> DONE -> IDLE; GAP SHALL be skipped when WR_GAP=0.
REQ-018 SHALL leave IDLE when start_i=1 is sampled at cycle T; coeff_wr_o=1 with coeff_dat_o=buf[NCOEFF-1] SHALL appear at T+1.
REQ-019 SHALL stream the words in descending order buf[NCOEFF-1]..buf[0], since the filter's B cascade requires reverse programming; each word SHALL be presented for exactly one cycle with coeff_wr_o=1, and successive writes SHALL be WR_GAP+1 cycles apart.
REQ-020 SHALL hold coeff_dat_o at the last-written value whenever coeff_wr_o=0.
REQ-021 SHALL assert coeff_update_o for exactly one cycle, WR_GAP+1 cycles after the last write, and never concurrently with coeff_wr_o.
REQ-022 SHALL pulse done_o for exactly one cycle, on the cycle after coeff_update_o.
REQ-023 SHALL drive busy_o=1 from T+1 through the coeff_update_o cycle inclusive; busy_o SHALL be 0 in the done_o cycle.
REQ-024 SHALL define the total sequence length as NCOEFF*(WR_GAP+1)+1 busy cycles.
REQ-025 SHALL, while busy, ignore start_i and host_wr_i; either strobe SHALL set err_o and SHALL leave the buffer unmodified.
REQ-026 SHALL accept start_i in the done_o cycle, with the FSM then in IDLE, as a new request.
REQ-027 SHALL, when host_wr_i and start_i are sampled together in IDLE, perform the write first so the streamed data includes it.
REQ-028 SHALL clear err_o only by reset.

Reset
REQ-029 SHALL, while rst=1, asynchronously force the FSM to IDLE, the buffer to all zeros, and all outputs to 0, including coeff_dat_o.
REQ-030 SHALL, on reset mid-sequence, abort with no further coeff_wr_o or coeff_update_o and no done_o pulse.
REQ-031 SHALL resume normal operation on the first clock edge after rst deasserts.

Configuration
REQ-032 SHALL, when COEFF_READBACK_EN is defined, add input host_rd_i (1 bit), output host_dat_o (18 bits) and output host_valid_o (1 bit).
REQ-033 SHALL, in that configuration, return buf[host_addr_i] on host_dat_o with host_valid_o=1 one cycle after host_rd_i, in any state; an out-of-range address SHALL return 0 with host_valid_o=1.
REQ-034 SHALL, when COEFF_READBACK_EN is undefined, omit these ports and their logic entirely.

Verification
REQ-035 SHALL test NCOEFF=2, WR_GAP=0, buf={0x00011,0x3FFFF}, start at T -> wr at T+1 with 0x3FFFF, wr at T+2 with 0x00011, update at T+3, done at T+4.
REQ-036 SHALL test NCOEFF=4, WR_GAP=2 -> writes at T+1,4,7,10, update at T+13, done at T+14, busy for 13 cycles.
REQ-037 SHALL test a host write and a start mid-sequence -> buffer unchanged, err_o=1 until reset, streamed words unchanged.
REQ-038 SHALL test rst asserted between the first and second write -> all outputs 0 immediately, no update or done pulse, buffer reads 0.
REQ-039 SHALL test simultaneous host write to address NCOEFF-1 with value 0x12345 and start in IDLE -> the first streamed word is 0x12345.
REQ-040 SHALL test, with COEFF_READBACK_EN defined, a write of 0x2AAAA to address 1 then a read of address 1 -> host_dat_o=0x2AAAA with host_valid_o=1 one cycle later.

Source files
------------

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader
// Holds NCOEFF 18-bit coefficient words written by a host. On start_i it
// streams them to the biquad filter in descending order, buf[NCOEFF-1] down to
// buf[0], with WR_GAP idle cycles after each word. It then issues a
// coeff_update strobe and a done pulse.
// Optional feature: define COEFF_READBACK_EN to add a registered host readback
// port (host_rd_i / host_dat_o / host_valid_o).
module biquad8_coeff_loader #(
   parameter int NCOEFF    = 2,
   parameter int ADDR_BITS = 3,
   parameter int WR_GAP    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] host_addr_i,
   input  logic [17:0]          host_dat_i,
   input  logic                 host_wr_i,
   input  logic                 start_i,
`ifdef COEFF_READBACK_EN
   input  logic                 host_rd_i,
   output logic [17:0]          host_dat_o,
   output logic                 host_valid_o,
`endif
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [17:0]          coeff_dat_o,
   output logic                 coeff_wr_o,
   output logic                 coeff_update_o
);

   localparam int                   DW        = 18;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NCOEFF - 1);
   localparam logic [3:0]           GAP_LOAD  = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

   // S_DONE is the done_o cycle. For host traffic it behaves exactly like
   // S_IDLE, so a start_i arriving in that cycle begins a new load.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_GAP,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [ADDR_BITS-1:0] idx_q;        // index of the word most recently streamed
   logic [3:0]           gap_q;        // idle cycles still to wait in S_GAP
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;
   logic                 coeff_wr_q;
   logic                 coeff_upd_q;
   logic [DW-1:0]        coeff_dat_q;
   logic [DW-1:0]        buf_q [NCOEFF];

   logic                 host_open;    // host may write and start
   logic                 addr_ok;
   logic                 buf_wr;
   logic                 strobe_err;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [DW-1:0]        stream_word;

   assign host_open  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign addr_ok    = int'(host_addr_i) < NCOEFF;
   assign buf_wr     = host_open && host_wr_i && addr_ok;
   assign strobe_err = !host_open && (host_wr_i || start_i);

   // Select the next word to stream: the top entry when a load starts, otherwise the entry below idx_q.
   always_comb begin
      // NOTE: give every combinational output a default first so that no path leaves it unassigned and infers a latch.
      stream_word = '0;
      rd_addr     = host_open ? LAST_ADDR : idx_q - ADDR_BITS'(1);
      for (int i = 0; i < NCOEFF; i++) begin
         if (rd_addr == ADDR_BITS'(i)) begin
            stream_word = buf_q[i];
         end
      end
      // A host write in the same cycle as start takes effect first, so forward it.
      if (host_open && buf_wr && host_addr_i == LAST_ADDR) begin
         stream_word = host_dat_i;
      end
   end

   // Coefficient buffer: host writes accepted only while the loader is not busy.
   // NOTE: this storage is cleared by reset on purpose, because a load issued straight after reset must stream zeros. Plain RAM-style buffers would normally skip the reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCOEFF; i++) begin
            buf_q[i] <= '0;
         end
      end else if (buf_wr) begin
         for (int i = 0; i < NCOEFF; i++) begin
            if (host_addr_i == ADDR_BITS'(i)) begin
               buf_q[i] <= host_dat_i;
            end
         end
      end
   end

   // Load sequencer: IDLE -> WRITE (-> GAP) ... -> UPDATE -> DONE, with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         gap_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         coeff_wr_q  <= 1'b0;
         coeff_upd_q <= 1'b0;
         coeff_dat_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking <= so that every branch below sees the values from before this edge.
         coeff_wr_q  <= 1'b0;
         coeff_upd_q <= 1'b0;
         done_q      <= 1'b0;
         if (strobe_err) begin
            err_q <= 1'b1;
         end

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q     <= S_WRITE;
                  idx_q       <= LAST_ADDR;
                  coeff_wr_q  <= 1'b1;
                  coeff_dat_q <= stream_word;
                  busy_q      <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_WRITE, S_GAP: begin
               if (state_q == S_WRITE && WR_GAP != 0) begin
                  state_q <= S_GAP;
                  gap_q   <= GAP_LOAD;
               end else if (state_q == S_GAP && gap_q != 4'd0) begin
                  gap_q <= gap_q - 4'd1;
               end else if (idx_q == '0) begin
                  state_q     <= S_UPDATE;
                  coeff_upd_q <= 1'b1;
               end else begin
                  state_q     <= S_WRITE;
                  idx_q       <= idx_q - ADDR_BITS'(1);
                  coeff_wr_q  <= 1'b1;
                  coeff_dat_q <= stream_word;
               end
            end

            S_UPDATE: begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef COEFF_READBACK_EN
   logic [DW-1:0] host_rdat_q;
   logic          host_valid_q;
   logic [DW-1:0] host_word;

   // Readback mux: an address outside the buffer returns zero.
   always_comb begin
      host_word = '0;
      for (int i = 0; i < NCOEFF; i++) begin
         if (host_addr_i == ADDR_BITS'(i)) begin
            host_word = buf_q[i];
         end
      end
   end

   // Registered readback: the data and its valid flag appear one cycle after host_rd_i, in any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         host_rdat_q  <= '0;
         host_valid_q <= 1'b0;
      end else begin
         host_valid_q <= host_rd_i;
         if (host_rd_i) begin
            host_rdat_q <= host_word;
         end
      end
   end

   assign host_dat_o   = host_rdat_q;
   assign host_valid_o = host_valid_q;
`endif

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign coeff_dat_o    = coeff_dat_q;
   assign coeff_wr_o     = coeff_wr_q;
   assign coeff_update_o = coeff_upd_q;

endmodule
